// File: rtl/kmeans_pkg.sv
// kmeans_pkg: state encoding and default widths shared by the sum accumulator.
package kmeans_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 16;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/adder_w.sv
// adder_w: combinational WIDTH-bit adder with carry-in and carry-out.
module adder_w #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums len unsigned operands over a valid/ready stream and
// presents sum, sticky carry and count until the consumer takes the result.
module sum_accumulator
   import kmeans_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic [CNT_W-1:0] out_count,
   output logic             busy
);
   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_acc;
   logic               r_carry;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   r_len;
   logic [WIDTH-1:0]   w_sum;
   logic               w_cout;
   logic [CNT_W-1:0]   w_count_inc;
   logic               w_load;
   logic               w_accept;

   adder_w #(.WIDTH(WIDTH)) u_add (
      .a   (r_acc),
      .b   (in_data),
      .cin (1'b0),
      .sum (w_sum),
      .cout(w_cout)
   );

   assign w_count_inc = r_count + 1'b1;
   assign w_load      = (r_state == IDLE) && start;
   assign w_accept    = (r_state == ACCUM) && in_valid;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   // handshake outputs decode the state register only, never in_valid
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      w_next    = (r_state == IDLE)  ? (start ? ((len == '0) ? DONE : ACCUM) : IDLE) :
                  (r_state == ACCUM) ? ((w_accept && (w_count_inc == r_len)) ? DONE : ACCUM) :
                  (r_state == DONE)  ? (out_ready ? IDLE : DONE) : IDLE;
      in_ready  = (r_state == ACCUM);
      out_valid = (r_state == DONE);
      busy      = (r_state != IDLE);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_count <= '0;
         r_len   <= '0;
      end else if (w_load) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_count <= '0;
         r_len   <= len;
      end else if (w_accept) begin
         r_acc   <= w_sum;
         r_carry <= r_carry | w_cout;
         r_count <= w_count_inc;
      end

   assign out_sum   = r_acc;
   assign out_carry = r_carry;
   assign out_count = r_count;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed and randomized jobs checked against a 64-bit
// arithmetic reference (sum mod 2^32, carry = true total reached 2^32).
module tb_sum_accumulator;
   localparam int WIDTH = 32;
   localparam int CNT_W = 16;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] len = '0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;
   logic [CNT_W-1:0] out_count;
   logic             busy;
   int               n_vec = 0;
   int               n_err = 0;
   logic [WIDTH-1:0] q[$];

   always #5 clk = ~clk;

   sum_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_carry(out_carry),
      .out_count(out_count),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_sum"}, out_sum, 0);
      check({tag, "_carry"}, out_carry, 0);
      check({tag, "_count"}, out_count, 0);
   endtask

   // one full job over the operands in q; gap1 idle cycles before operand 1
   task automatic run_job(input int gap1, input int max_gap, input int hold, input bit start_in_done);
      longint unsigned tot = 0;
      int n = q.size();
      int g;
      start = 1'b1;
      len = CNT_W'(n);
      tick;
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         check("in_ready", in_ready, 1);
         check("busy_accum", busy, 1);
         check("ov_accum", out_valid, 0);
         g = ((i == 1) ? gap1 : 0) + int'($urandom_range(max_gap, 0));
         repeat (g) begin
            in_valid = 1'b0;
            in_data = $urandom;
            tick;
            check("gap_count", out_count, 64'(i));
            check("gap_sum", out_sum, tot & 64'hFFFF_FFFF);
            check("gap_ready", in_ready, 1);
         end
         in_valid = 1'b1;
         in_data = q[i];
         tick;
         in_valid = 1'b0;
         tot += q[i];
         check("run_count", out_count, 64'(i + 1));
         check("run_sum", out_sum, tot & 64'hFFFF_FFFF);
         check("run_carry", out_carry, 64'(tot >= 64'h1_0000_0000));
      end
      check("done_valid", out_valid, 1);
      check("done_busy", busy, 1);
      check("done_ready", in_ready, 0);
      check("done_sum", out_sum, tot & 64'hFFFF_FFFF);
      check("done_carry", out_carry, 64'(tot >= 64'h1_0000_0000));
      check("done_count", out_count, 64'(n));
      repeat (hold) begin
         start = start_in_done;
         len = 16'd7;
         tick;
         start = 1'b0;
         check("hold_valid", out_valid, 1);
         check("hold_sum", out_sum, tot & 64'hFFFF_FFFF);
         check("hold_carry", out_carry, 64'(tot >= 64'h1_0000_0000));
         check("hold_count", out_count, 64'(n));
      end
      out_ready = 1'b1;
      start = start_in_done;
      len = 16'd5;
      tick;
      out_ready = 1'b0;
      start = 1'b0;
      check("hs_valid", out_valid, 0);
      check("hs_busy", busy, 0);
      tick;
      check("idle_busy", busy, 0);
   endtask

   initial begin
      #2;
      check_idle_zero("por");
      tick;
      rst = 1'b0;
      tick;
      check("idle_wait", busy, 0);
      q = '{32'd512, 32'd16};
      run_job(0, 0, 0, 0);
      q = '{32'd256, 32'd0, 32'd1};
      run_job(4, 0, 0, 0);
      q = '{32'hFFFF_FFFF, 32'd2};
      run_job(0, 0, 0, 0);
      q = '{32'd5};
      run_job(0, 0, 0, 0);
      q.delete();
      run_job(0, 0, 0, 0);
      q = '{32'd3, 32'd4};
      run_job(0, 0, 5, 1);
      start = 1'b1;
      len = 16'd3;
      tick;
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 32'd77;
      tick;
      in_valid = 1'b0;
      check("pre_rst_count", out_count, 1);
      #2;
      rst = 1'b1;
      #1;
      check_idle_zero("mid_rst");
      tick;
      tick;
      rst = 1'b0;
      tick;
      tick;
      check("post_rst_idle", busy, 0);
      q = '{32'd9, 32'd10, 32'd11};
      run_job(0, 1, 1, 0);
      for (int j = 0; j < 40; j++) begin
         q.delete();
         repeat ($urandom_range(6, 0))
            q.push_back(($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom);
         run_job(0, $urandom_range(2, 0), $urandom_range(3, 0), 1'($urandom_range(1, 0)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
